// File: rtl/nand_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined bitwise-NAND unit among N_REQ requesters.
// Results return in issue order to their issuer; a blocked head response stalls the whole pipe.
module nand_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int              PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]  N_EXT    = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  function automatic logic [WIDTH-1:0] nand_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return ~(a & b);
  endfunction

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [LAT-1:0]              vld_q, vld_d;
  logic [LAT-1:0][PTR_W-1:0]   tag_q, tag_d;
  logic [LAT-1:0][WIDTH-1:0]   data_q, data_d;

  logic [PTR_W:0]   scan_idx;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;
  logic             stall;
  logic             fire;
  logic [WIDTH-1:0] a_sel, b_sel;

  // Scan from ptr upward with wrap; idle requesters cost nothing.
  always_comb begin
    scan_idx  = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= N_EXT) scan_idx = scan_idx - N_EXT;
      if (!gnt_found && req_valid[scan_idx[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign stall     = vld_q[LAT-1] && !rsp_ready[tag_q[LAT-1]];
  assign fire      = gnt_found && !stall && !rst;
  assign req_ready = fire ? (N_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 0 takes the granted op; later stages shift only when the head can move.
  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (!stall) begin
      vld_d[0]  = fire;
      tag_d[0]  = gnt_idx;
      data_d[0] = fire ? nand_op(a_sel, b_sel) : '0;
      for (int k = 1; k < LAT; k++) begin
        vld_d[k]  = vld_q[k-1];
        tag_d[k]  = tag_q[k-1];
        data_d[k] = data_q[k-1];
      end
      if (fire) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      vld_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  // Head of pipe drives the response
  assign rsp_valid = vld_q[LAT-1] ? (N_REQ'(1) << tag_q[LAT-1]) : '0;
  assign rsp_data  = vld_q[LAT-1] ? data_q[LAT-1] : '0;
  assign busy      = |vld_q;

endmodule

// File: doc/nand_rr_arbiter.md
Name: nand_rr_arbiter

Overview:
- Shares one pipelined 8-bit bitwise-NAND unit among N_REQ requesters.
- Each requester issues an operand pair through a valid/ready handshake.
- A round-robin scheduler grants at most one requester per cycle.
- Each result is routed back to its issuer with a one-hot response valid and per-requester backpressure.
- Sits inside tt_10_ef6404_nand between the ui_in/uio_in decode logic and the uo_out drive logic.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 8, operand/result width in bits.
- LAT, 2, pipeline depth of the shared NAND unit in register stages (>=1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset; top level drives rst = ~rst_n.
- req_valid  input  N_REQ  request valid, bit i = requester i.
- req_ready  output  N_REQ  one-hot grant, at most one bit high.
- req_a  input  N_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  packed operand B, same packing.
- rsp_valid  output  N_REQ  one-hot response valid, bit = tag of head result.
- rsp_ready  input  N_REQ  per-requester response accept.
- rsp_data  output  WIDTH  result ~(a & b) of head entry.
- busy  output  1  high when any pipeline stage holds a valid entry.

Behaviour:
Decision: one clock; reset is synchronous and active-high.

State:
- Round-robin pointer ptr, width clog2(N_REQ).
- LAT stages, each {vld, tag, data}.

Reset (rst=1 at rising edge):
- ptr<=0; all stage vld<=0, tag<=0, data<=0.
- While rst=1, req_ready is forced to 0 combinationally.
- Outputs after reset: req_ready=0 (until a request is seen), rsp_valid=0, rsp_data=0, busy=0.

Stall and grant:
- stall = last.vld && !rsp_ready[last.tag].
- Grant (combinational): if rst or stall, req_ready=0.
  - Otherwise scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
- Handshake: in a cycle where req_valid[i] && req_ready[i], the edge loads stage0 with {1, i, ~(a_i & b_i)}.
  - ptr<=(i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - With no handshake, ptr holds.

Pipeline:
- If !stall, every stage k loads stage k-1 on the edge.
- Stage0 loads the granted entry, or vld=0 if nothing was granted.
- If stall, all stages and ptr hold; nothing is lost or duplicated.

Response:
- rsp_valid = last.vld ? (1<<last.tag) : 0.
- rsp_data = last.vld ? last.data : 0.
- Response is consumed when rsp_valid[t] && rsp_ready[t].
- While stalled, rsp_valid and rsp_data hold stable.

Timing:
- Latency: a handshake in cycle t gives rsp_valid in cycle t+LAT, absent stalls.
- Throughput: 1 op/cycle.
- Simultaneous retire of the head and issue of a new request in the same cycle is allowed.

Other rules:
- busy = OR of all stage vld.
- Requesters must hold req_valid and operands stable until ready; the block does not check this.
- Reset mid-operation: all in-flight entries are discarded and no response is produced for them. ptr returns to 0.
- Response ordering is issue order, so responses to one requester are never reordered.
- Requesters whose req_valid is low are skipped without consuming a slot.

Test Plan:
1. Reset: rst=1 for 2 cycles with req_valid=4'hF, rsp_ready=4'hF -> req_ready=0, rsp_valid=0, busy=0 throughout. First cycle after release: req_ready=4'b0001.
2. Single op: req_valid=4'b0010, req_a[1]=8'hF0, req_b[1]=8'h3C in cycle t -> req_ready=4'b0010 in cycle t. Cycle t+2: rsp_valid=4'b0010, rsp_data=8'hCF, busy=1. Cycle t+3: busy=0.
3. Round robin: req_valid=4'hF held, rsp_ready=4'hF, operands a_i=8'hFF, b_i=8'hF0|i -> grants cycle by cycle 0,1,2,3,0. Responses back-to-back with rsp_data 8'h0F, 8'h0E, 8'h0D, 8'h0C in grant order.
4. Skip/wrap: after a grant to requester 0, req_valid=4'b1001 held -> next grants are 3, then 0, then 3. No cycle is lost to idle requesters.
5. Backpressure: rsp_ready[2]=0 while the head tag is 2, for 3 cycles -> rsp_valid=4'b0100 and rsp_data constant, req_ready=0, ptr unchanged. After rsp_ready[2]=1, the held result retires once and the remaining entries follow with no gaps or duplicates.
6. Reset mid-flight: issue 2 ops, then assert rst for 1 cycle before either responds -> rsp_valid stays 0 for 5 cycles, busy=0. The next grant goes to the lowest valid index from ptr=0.
